// File: rtl/bus_xfer_pkg.sv
// Shared encodings for the bus transfer engine.
// Command opcodes and FSM state names.
package bus_xfer_pkg;

  typedef enum logic [1:0] {
    OP_NOP  = 2'b00,
    OP_LOAD = 2'b01,
    OP_MOVE = 2'b10,
    OP_READ = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_XFER = 2'b01,
    ST_RESP = 2'b10
  } state_e;

endpackage

// File: rtl/xfer_regfile.sv
// General register file for the bus transfer engine.
// One sync write port, combinational source and debug reads.
module xfer_regfile #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 16,
  parameter int REG_ADDR_W = 4,
  parameter int R0_ZERO    = 0
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic                  we,
  input  logic [REG_ADDR_W-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [REG_ADDR_W-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata,
  input  logic [REG_ADDR_W-1:0] dbg_addr,
  output logic [DATA_WIDTH-1:0] dbg_data
);

  logic [DATA_WIDTH-1:0] mem [NUM_REGS];

  // Out-of-range slots and a hardwired R0 never hold data.
  function automatic logic live(input logic [REG_ADDR_W-1:0] a);
    return (32'(a) < NUM_REGS) && !((R0_ZERO != 0) && (a == '0));
  endfunction

  assign rdata    = live(raddr) ? mem[raddr] : '0;
  assign dbg_data = live(dbg_addr) ? mem[dbg_addr] : '0;

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        mem[i] <= '0;
      end
    end else if (we && live(waddr)) begin
      mem[waddr] <= wdata;
    end
  end

endmodule

// File: rtl/bus_transfer_engine.sv
// Command-driven register transfer engine: regfile, MDR, shared bus.
// LOAD, MOVE and READ each run as a fixed three-cycle sequence.
module bus_transfer_engine
  import bus_xfer_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 16,
  parameter int REG_ADDR_W = 4,
  parameter int R0_ZERO    = 0
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [REG_ADDR_W-1:0] cmd_src,
  input  logic [REG_ADDR_W-1:0] cmd_dst,
  input  logic [DATA_WIDTH-1:0] mdata_in,
  output logic [DATA_WIDTH-1:0] bus_out,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_err,
  input  logic [REG_ADDR_W-1:0] dbg_addr,
  output logic [DATA_WIDTH-1:0] dbg_data
);

  state_e                state;
  op_e                   op;
  logic [REG_ADDR_W-1:0] src;
  logic [REG_ADDR_W-1:0] dst;
  logic [DATA_WIDTH-1:0] mdr;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  src_bad;
  logic                  dst_bad;
  logic                  xfer_err;
  logic                  wr;

  assign cmd_ready = (state == ST_IDLE) && !clear;
  assign src_bad   = 32'(src) >= NUM_REGS;
  assign dst_bad   = 32'(dst) >= NUM_REGS;

  always_comb begin
    xfer_err = 1'b0;
    case (op)
      OP_LOAD: xfer_err = dst_bad;
      OP_MOVE: xfer_err = src_bad || dst_bad;
      OP_READ: xfer_err = src_bad;
      default: xfer_err = 1'b0;
    endcase
  end

  assign bus_out = (state != ST_XFER) ? '0 :
                   (op == OP_LOAD)    ? mdr : rdata;

  assign wr = (state == ST_XFER) && !xfer_err &&
              ((op == OP_LOAD) || (op == OP_MOVE));

  xfer_regfile #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_REGS   (NUM_REGS),
    .REG_ADDR_W (REG_ADDR_W),
    .R0_ZERO    (R0_ZERO)
  ) u_regs (
    .clock    (clock),
    .clear    (clear),
    .we       (wr),
    .waddr    (dst),
    .wdata    (bus_out),
    .raddr    (src),
    .rdata    (rdata),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state     <= ST_IDLE;
      op        <= OP_NOP;
      src       <= '0;
      dst       <= '0;
      mdr       <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          rsp_valid <= 1'b0;
          if (cmd_valid) begin
            op  <= op_e'(cmd_op);
            src <= cmd_src;
            dst <= cmd_dst;
            if (op_e'(cmd_op) == OP_LOAD) mdr <= mdata_in;
            if (op_e'(cmd_op) != OP_NOP) state <= ST_XFER;
          end
        end
        ST_XFER: begin
          rsp_valid <= 1'b1;
          rsp_data  <= xfer_err ? '0 : bus_out;
          rsp_err   <= xfer_err;
          state     <= ST_RESP;
        end
        ST_RESP: begin
          rsp_valid <= 1'b0;
          state     <= ST_IDLE;
        end
        default: begin
          rsp_valid <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
